// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Fetch stage for the AAP pipeline. Owns the program counter, issues one
// word-addressed request per cycle to instruction memory (fixed latency of
// one cycle), buffers the returned 16-bit words in a DEPTH-entry prefetch
// queue and presents the two oldest words to decode as a 32-bit window.
// Supports relative/absolute redirects, flush with replay from the oldest
// unconsumed PC, and decode back-pressure through out_consume.
//
// Ports
//   clock            rising-edge clock
//   reset            synchronous, active-high reset
//   imem_addr        fetch address (the PC register)
//   imem_req         fetch request this cycle
//   imem_data        word returned for the request issued last cycle
//   redirect_en      branch/jump taken this cycle
//   redirect_abs     1: absolute target, 0: base + sign-extended offset
//   redirect_base    PC of the branch instruction
//   redirect_offset  signed relative offset
//   redirect_target  absolute target
//   flush            discard queue and in-flight word, replay oldest PC
//   out_insn         {oldest, second-oldest} word, NOP in absent slots
//   out_pc           PC of the oldest word (holds when queue is empty)
//   out_avail        words valid in the window, min(count, 2)
//   out_consume      words decode takes this cycle (0..out_avail)
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int                ADDR_W   = 20,
    parameter int                INSN_W   = 16,
    parameter int                DEPTH    = 4,
    parameter int                OFFSET_W = 9,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [INSN_W-1:0] NOP      = 'h1
) (
    input  logic                clock,
    input  logic                reset,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic                imem_req,
    input  logic [INSN_W-1:0]   imem_data,
    input  logic                redirect_en,
    input  logic                redirect_abs,
    input  logic [ADDR_W-1:0]   redirect_base,
    input  logic [OFFSET_W-1:0] redirect_offset,
    input  logic [ADDR_W-1:0]   redirect_target,
    input  logic                flush,
    output logic [2*INSN_W-1:0] out_insn,
    output logic [ADDR_W-1:0]   out_pc,
    output logic [1:0]          out_avail,
    input  logic [1:0]          out_consume
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [ADDR_W-1:0] pc_q,   pc_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              epoch_q, epoch_d;
    logic              infl_valid_q;
    logic              infl_epoch_q;
    logic [ADDR_W-1:0] infl_pc_q;
    logic [ADDR_W-1:0] held_pc_q;

    logic [INSN_W-1:0] word_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];

    // -----------------------------------------------------------------------
    // Combinational control
    // -----------------------------------------------------------------------
    logic              steer;          // redirect or flush this cycle
    logic [1:0]        consume_eff;
    logic [CNT_W:0]    occupancy;      // entries held after this cycle's consume
    logic              write_en;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  head_next1;
    logic [ADDR_W-1:0] rel_target;
    logic [ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0] replay_pc;

    assign steer       = redirect_en | flush;
    // Decode's consume is meaningless once the queue is being thrown away.
    assign consume_eff = steer ? 2'd0 : out_consume;

    assign occupancy = {1'b0, count_q}
                     - {{(CNT_W - 1){1'b0}}, consume_eff}
                     + {{CNT_W{1'b0}}, infl_valid_q};

    assign imem_req  = !reset && !steer && (occupancy < DEPTH_C);
    assign imem_addr = pc_q;

    // A response is kept only if it belongs to the current epoch and the
    // queue is not being discarded at this same edge.
    assign write_en = infl_valid_q && (infl_epoch_q == epoch_q) && !steer;

    // count never equals DEPTH when a write lands, so the low bits suffice.
    assign tail       = head_q + count_q[PTR_W-1:0];
    assign head_next1 = head_q + PTR_W'(1);

    assign rel_target = redirect_base
                      + {{(ADDR_W - OFFSET_W){redirect_offset[OFFSET_W-1]}}, redirect_offset};
    assign redirect_pc = redirect_abs ? redirect_target : rel_target;

    // Replay source: oldest buffered word, else the outstanding request,
    // else nothing was fetched past the PC so it stays where it is.
    always_comb begin
        if (count_q != '0) begin
            replay_pc = pc_mem[head_q];
        end else if (infl_valid_q) begin
            replay_pc = infl_pc_q;
        end else begin
            replay_pc = pc_q;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the if/else can leave a value held (no latch).
    always_comb begin
        pc_d    = pc_q;
        head_d  = head_q;
        count_d = count_q;
        epoch_d = epoch_q;

        if (redirect_en) begin
            pc_d    = redirect_pc;
            count_d = '0;
            epoch_d = ~epoch_q;
        end else if (flush) begin
            pc_d    = replay_pc;
            count_d = '0;
            epoch_d = ~epoch_q;
        end else begin
            head_d  = head_q + PTR_W'(consume_eff);
            count_d = count_q + CNT_W'(write_en) - CNT_W'(consume_eff);
            if (imem_req) begin
                pc_d = pc_q + ADDR_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Sequential state
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            head_q       <= '0;
            count_q      <= '0;
            epoch_q      <= 1'b0;
            infl_valid_q <= 1'b0;
            infl_epoch_q <= 1'b0;
            infl_pc_q    <= '0;
            held_pc_q    <= '0;
        end else begin
            pc_q         <= pc_d;
            head_q       <= head_d;
            count_q      <= count_d;
            epoch_q      <= epoch_d;
            infl_valid_q <= imem_req;
            held_pc_q    <= out_pc;
            if (imem_req) begin
                infl_pc_q    <= pc_q;
                infl_epoch_q <= epoch_q;
            end
        end
    end

    // NOTE: the queue storage has no reset; entries are only read when count
    // says they are valid, so clearing them would cost logic for nothing.
    always_ff @(posedge clock) begin
        if (!reset && write_en) begin
            word_mem[tail] <= imem_data;
            pc_mem[tail]   <= infl_pc_q;
        end
    end

    // -----------------------------------------------------------------------
    // Decode window
    // -----------------------------------------------------------------------
    always_comb begin
        out_avail = 2'd0;
        out_insn  = {NOP, NOP};
        out_pc    = held_pc_q;

        if (count_q >= CNT_W'(2)) begin
            out_avail = 2'd2;
        end else begin
            out_avail = count_q[1:0];
        end

        if (count_q != '0) begin
            out_insn[2*INSN_W-1:INSN_W] = word_mem[head_q];
            out_pc                      = pc_mem[head_q];
        end
        if (count_q >= CNT_W'(2)) begin
            out_insn[INSN_W-1:0] = word_mem[head_next1];
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//
// Directed bench for fetch_queue with default parameters. A one-cycle
// memory model returns the low 16 bits of the requested address (0xDEAD on
// cycles without a request). Expected values are hand-computed per cycle.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

    logic        clock;
    logic        reset;
    logic [19:0] imem_addr;
    logic        imem_req;
    logic [15:0] imem_data;
    logic        redirect_en;
    logic        redirect_abs;
    logic [19:0] redirect_base;
    logic [8:0]  redirect_offset;
    logic [19:0] redirect_target;
    logic        flush;
    logic [31:0] out_insn;
    logic [19:0] out_pc;
    logic [1:0]  out_avail;
    logic [1:0]  out_consume;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] NOP2 = 32'h0001_0001;

    fetch_queue dut (
        .clock           (clock),
        .reset           (reset),
        .imem_addr       (imem_addr),
        .imem_req        (imem_req),
        .imem_data       (imem_data),
        .redirect_en     (redirect_en),
        .redirect_abs    (redirect_abs),
        .redirect_base   (redirect_base),
        .redirect_offset (redirect_offset),
        .redirect_target (redirect_target),
        .flush           (flush),
        .out_insn        (out_insn),
        .out_pc          (out_pc),
        .out_avail       (out_avail),
        .out_consume     (out_consume)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Decode must never take more than the window offers.
    always @(negedge clock) begin
        if (!reset && !redirect_en && !flush && (out_consume > out_avail)) begin
            $error("illegal out_consume %0d with out_avail %0d", out_consume, out_avail);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; the memory model answers the request seen before the edge.
    task automatic next_cycle();
        logic        req;
        logic [19:0] addr;
        req  = imem_req;
        addr = imem_addr;
        @(posedge clock);
        #1;
        imem_data = req ? addr[15:0] : 16'hDEAD;
    endtask

    task automatic drive(input logic [1:0] cons, input logic red, input logic abs,
                         input logic [19:0] base, input logic [8:0] off,
                         input logic [19:0] tgt, input logic fl);
        next_cycle();
        out_consume     = cons;
        redirect_en     = red;
        redirect_abs    = abs;
        redirect_base   = base;
        redirect_offset = off;
        redirect_target = tgt;
        flush           = fl;
        #1;
    endtask

    task automatic idle(input logic [1:0] cons);
        drive(cons, 1'b0, 1'b0, 20'h0, 9'h0, 20'h0, 1'b0);
    endtask

    initial begin
        logic [15:0] w;
        reset           = 1'b1;
        redirect_en     = 1'b0;
        redirect_abs    = 1'b0;
        redirect_base   = '0;
        redirect_offset = '0;
        redirect_target = '0;
        flush           = 1'b0;
        out_consume     = 2'd0;
        imem_data       = 16'hDEAD;

        // Reset state
        idle(0);
        idle(0);
        check("rst_req",   32'(imem_req),  32'h0);
        check("rst_addr",  32'(imem_addr), 32'h0);
        check("rst_avail", 32'(out_avail), 32'h0);
        check("rst_insn",  out_insn,       NOP2);
        check("rst_pc",    32'(out_pc),    32'h0);

        // 1: streaming with consume=1, no bubbles
        reset = 1'b0;
        #1;
        check("t1_req0",   32'(imem_req),  32'h1);
        check("t1_addr0",  32'(imem_addr), 32'h0);
        check("t1_avail0", 32'(out_avail), 32'h0);
        idle(0);
        check("t1_addr1",  32'(imem_addr), 32'h1);
        check("t1_avail1", 32'(out_avail), 32'h0);
        for (int i = 2; i < 12; i++) begin
            idle(1);
            w = 16'(i - 2);
            check("t1_req",   32'(imem_req),  32'h1);
            check("t1_addr",  32'(imem_addr), 32'(i));
            check("t1_avail", 32'(out_avail), 32'h1);
            check("t1_insn",  out_insn,       {w, 16'h0001});
            check("t1_pc",    32'(out_pc),    32'(i - 2));
        end

        // 2: back-pressure fills exactly DEPTH entries, then resume
        idle(0);
        reset = 1'b1;
        #1;
        idle(0);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) idle(0);
            check("t2_req",   32'(imem_req),  (i < 4) ? 32'h1 : 32'h0);
            check("t2_addr",  32'(imem_addr), (i < 4) ? 32'(i) : 32'h4);
            check("t2_avail", 32'(out_avail), (i < 2) ? 32'h0 : ((i == 2) ? 32'h1 : 32'h2));
        end
        check("t2_insn_full", out_insn,    32'h0000_0001);
        check("t2_pc_full",   32'(out_pc), 32'h0);
        for (int j = 0; j < 6; j++) begin
            idle(1);
            w = 16'(j);
            check("t2_insn",  out_insn,       {w, w + 16'h1});
            check("t2_pc",    32'(out_pc),    32'(j));
            check("t2_avail", 32'(out_avail), 32'h2);
            check("t2_addr",  32'(imem_addr), 32'(4 + j));
        end

        // 3: absolute redirect with a word in flight
        drive(1, 1'b1, 1'b1, 20'h0, 9'h0, 20'h00100, 1'b0);
        check("t3_req_redir", 32'(imem_req), 32'h0);
        idle(0);
        check("t3_req1",   32'(imem_req),  32'h1);
        check("t3_addr1",  32'(imem_addr), 32'h00100);
        check("t3_avail1", 32'(out_avail), 32'h0);
        check("t3_pc_hold", 32'(out_pc),   32'h6);
        idle(0);
        check("t3_avail2", 32'(out_avail), 32'h0);
        check("t3_addr2",  32'(imem_addr), 32'h00101);
        idle(0);
        check("t3_avail3", 32'(out_avail), 32'h1);
        check("t3_pc3",    32'(out_pc),    32'h00100);
        check("t3_insn3",  out_insn,       32'h0100_0001);

        // 4: relative redirects wrapping both ways
        drive(0, 1'b1, 1'b0, 20'h00002, 9'h1FD, 20'h0, 1'b0);
        check("t4_req_redir", 32'(imem_req), 32'h0);
        idle(0);
        check("t4_addr_neg", 32'(imem_addr), 32'hFFFFF);
        check("t4_req_neg",  32'(imem_req),  32'h1);
        drive(0, 1'b1, 1'b0, 20'hFFFFF, 9'h001, 20'h0, 1'b0);
        check("t4_pc_incwrap", 32'(imem_addr), 32'h00000);
        check("t4_req_redir2", 32'(imem_req),  32'h0);
        idle(0);
        check("t4_addr_pos", 32'(imem_addr), 32'h00000);
        check("t4_req_pos",  32'(imem_req),  32'h1);
        idle(0);
        check("t4_addr_next", 32'(imem_addr), 32'h00001);
        idle(0);
        check("t4_avail", 32'(out_avail), 32'h1);
        check("t4_pc",    32'(out_pc),    32'h0);
        check("t4_insn",  out_insn,       32'h0000_0001);

        // 5: flush with queue holding PCs 7,8,9 (and 10 in flight)
        drive(0, 1'b1, 1'b1, 20'h0, 9'h0, 20'h00007, 1'b0);
        idle(0);
        idle(0);
        idle(0);
        idle(0);
        drive(0, 1'b0, 1'b0, 20'h0, 9'h0, 20'h0, 1'b1);
        check("t5_avail_pre", 32'(out_avail), 32'h2);
        check("t5_insn_pre",  out_insn,       32'h0007_0008);
        check("t5_pc_pre",    32'(out_pc),    32'h7);
        check("t5_req_flush", 32'(imem_req),  32'h0);
        idle(0);
        check("t5_addr",  32'(imem_addr), 32'h7);
        check("t5_req",   32'(imem_req),  32'h1);
        check("t5_avail", 32'(out_avail), 32'h0);
        idle(0);
        idle(0);
        check("t5_avail2", 32'(out_avail), 32'h1);
        check("t5_pc2",    32'(out_pc),    32'h7);
        check("t5_insn2",  out_insn,       32'h0007_0001);

        // 5b: flush with empty queue replays the in-flight PC
        drive(0, 1'b1, 1'b1, 20'h0, 9'h0, 20'h00040, 1'b0);
        idle(0);
        check("t5b_addr_issue", 32'(imem_addr), 32'h00040);
        drive(0, 1'b0, 1'b0, 20'h0, 9'h0, 20'h0, 1'b1);
        check("t5b_req_flush", 32'(imem_req),  32'h0);
        check("t5b_pc_ahead",  32'(imem_addr), 32'h00041);
        idle(0);
        check("t5b_addr_replay", 32'(imem_addr), 32'h00040);
        check("t5b_req_replay",  32'(imem_req),  32'h1);

        // 6: redirect beats flush, then reset with a full queue
        idle(0);
        drive(0, 1'b1, 1'b1, 20'h0, 9'h0, 20'h00200, 1'b1);
        check("t6_req_both", 32'(imem_req), 32'h0);
        idle(0);
        check("t6_addr_win", 32'(imem_addr), 32'h00200);
        idle(0);
        idle(0);
        idle(0);
        idle(0);
        idle(0);
        check("t6_avail_full", 32'(out_avail), 32'h2);
        check("t6_req_full",   32'(imem_req),  32'h0);
        check("t6_addr_full",  32'(imem_addr), 32'h00204);
        check("t6_insn_full",  out_insn,       32'h0200_0201);
        check("t6_pc_full",    32'(out_pc),    32'h00200);
        idle(0);
        reset           = 1'b1;
        redirect_en     = 1'b1;
        redirect_abs    = 1'b1;
        redirect_target = 20'h00300;
        #1;
        check("t6_req_in_rst", 32'(imem_req), 32'h0);
        next_cycle();
        #1;
        check("t6_rst_addr",  32'(imem_addr), 32'h0);
        check("t6_rst_avail", 32'(out_avail), 32'h0);
        check("t6_rst_insn",  out_insn,       NOP2);
        check("t6_rst_pc",    32'(out_pc),    32'h0);
        check("t6_rst_req",   32'(imem_req),  32'h0);
        idle(0);
        reset = 1'b0;
        #1;
        check("t6_post_req",  32'(imem_req),  32'h1);
        check("t6_post_addr", 32'(imem_addr), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
